// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pc loop to pc_module, imem req/ack port, redirect/stall and IF/ID outputs.
// Stat counters exist only when FETCH_STATS_EN is defined.
interface fetch_stage_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pcNext;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_ack;
   logic [DATA_W-1:0] imem_rdata;
   logic              branch_taken;
   logic [ADDR_W-1:0] branch_target;
   logic              stall;
   logic              if_valid;
   logic [DATA_W-1:0] if_instr;
   logic [ADDR_W-1:0] if_pc;
`ifdef FETCH_STATS_EN
   logic [15:0]       stat_fetched;
   logic [15:0]       stat_stall;
`endif

   modport master (
      input  pc, imem_ack, imem_rdata, branch_taken, branch_target, stall,
      output pcNext, imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_STATS_EN
      , output stat_fetched, stat_stall
`endif
   );

   modport slave (
      output pc, imem_ack, imem_rdata, branch_taken, branch_target, stall,
      input  pcNext, imem_req, imem_addr, if_valid, if_instr, if_pc
`ifdef FETCH_STATS_EN
      , input stat_fetched, stat_stall
`endif
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch into IF/ID with 1-entry skid; ack in cycle N shows on IF/ID in N+1, pc advances N+1.
// stall holds IF/ID, one extra word parks in the skid with imem_req dropped; FETCH_STATS_EN adds counters.
module fetch_stage #(
   parameter int                ADDR_W   = 16,
   parameter int                DATA_W   = 16,
   parameter int                PC_STEP  = 1,
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
   input  logic         clk,
   input  logic         rst_n,
   fetch_stage_if.master bus
);
   typedef enum logic [1:0] {BOOT, FETCH, SKID, KILL} state_t;

   state_t            state, state_nxt;
   logic              if_valid_q, if_valid_nxt;
   logic [DATA_W-1:0] if_instr_q, if_instr_nxt;
   logic [ADDR_W-1:0] if_pc_q, if_pc_nxt;
   logic [DATA_W-1:0] skid_instr;
   logic [ADDR_W-1:0] skid_pc;
   logic              skid_load, skid_clr;
   logic [ADDR_W-1:0] redir_tgt, redir_nxt;
   logic [ADDR_W-1:0] pc_next, pc_inc;
   logic              req;
   logic              word_wr;

   assign pc_inc = bus.pc + ADDR_W'(PC_STEP);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= BOOT;
         if_valid_q <= 1'b0;
         if_instr_q <= '0;
         if_pc_q    <= '0;
         skid_instr <= '0;
         skid_pc    <= '0;
         redir_tgt  <= '0;
      end else begin
         state      <= state_nxt;
         if_valid_q <= if_valid_nxt;
         if_instr_q <= if_instr_nxt;
         if_pc_q    <= if_pc_nxt;
         redir_tgt  <= redir_nxt;
         if (skid_clr) begin
            skid_instr <= '0;
            skid_pc    <= '0;
         end else if (skid_load) begin
            skid_instr <= bus.imem_rdata;
            skid_pc    <= bus.pc;
         end
      end
   end

   // IF/ID default: hold while decode stalls, otherwise the entry drains.
   always_comb begin
      state_nxt    = state;
      pc_next      = bus.pc;
      req          = 1'b0;
      if_valid_nxt = if_valid_q & bus.stall;
      if_instr_nxt = if_instr_q;
      if_pc_nxt    = if_pc_q;
      skid_load    = 1'b0;
      skid_clr     = 1'b0;
      redir_nxt    = redir_tgt;
      word_wr      = 1'b0;
      case (state)
         BOOT: begin
            pc_next      = RESET_PC;
            if_valid_nxt = 1'b0;
            state_nxt    = FETCH;
         end
         FETCH: begin
            req = 1'b1;
            if (bus.branch_taken) begin
               if_valid_nxt = 1'b0;
               if (bus.imem_ack) begin
                  pc_next = bus.branch_target;
               end else begin
                  // address must stay put until the abandoned request is acked
                  redir_nxt = bus.branch_target;
                  state_nxt = KILL;
               end
            end else if (bus.imem_ack) begin
               pc_next = pc_inc;
               if (!if_valid_q || !bus.stall) begin
                  if_valid_nxt = 1'b1;
                  if_instr_nxt = bus.imem_rdata;
                  if_pc_nxt    = bus.pc;
                  word_wr      = 1'b1;
               end else begin
                  skid_load = 1'b1;
                  state_nxt = SKID;
               end
            end
         end
         SKID: begin
            if (bus.branch_taken) begin
               if_valid_nxt = 1'b0;
               skid_clr     = 1'b1;
               pc_next      = bus.branch_target;
               state_nxt    = FETCH;
            end else if (!bus.stall) begin
               if_valid_nxt = 1'b1;
               if_instr_nxt = skid_instr;
               if_pc_nxt    = skid_pc;
               word_wr      = 1'b1;
               skid_clr     = 1'b1;
               state_nxt    = FETCH;
            end
         end
         KILL: begin
            req          = 1'b1;
            if_valid_nxt = 1'b0;
            if (bus.branch_taken) begin
               redir_nxt = bus.branch_target;
            end
            if (bus.imem_ack) begin
               pc_next   = bus.branch_taken ? bus.branch_target : redir_tgt;
               state_nxt = FETCH;
            end
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

   assign bus.pcNext    = pc_next;
   assign bus.imem_req  = req;
   assign bus.imem_addr = bus.pc;
   assign bus.if_valid  = if_valid_q;
   assign bus.if_instr  = if_instr_q;
   assign bus.if_pc     = if_pc_q;

`ifdef FETCH_STATS_EN
   logic [15:0] stat_fetched_q, stat_stall_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         if (word_wr && stat_fetched_q != 16'hFFFF) begin
            stat_fetched_q <= stat_fetched_q + 16'd1;
         end
         if (if_valid_q && bus.stall && stat_stall_q != 16'hFFFF) begin
            stat_stall_q <= stat_stall_q + 16'd1;
         end
      end
   end

   assign bus.stat_fetched = stat_fetched_q;
   assign bus.stat_stall   = stat_stall_q;
`endif
endmodule
